wb_initiator: RTL and testbench

- Single-transaction bus master (initiator) for the strobe/ACK peripheral bus.
- Drives ADR/DAT/STB/WE toward the address decoder and responder ports (digital input port, digital output port, control register) and waits for the responder's ACK.
- Converts a one-cycle host request into exactly one bus cycle.
- Returns read data, a completion pulse, and an ACK-timeout flag.

---
 rtl/wb_initiator.sv | 131 +++++++++++++
 tb/tb_wb_initiator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Single-transaction strobe/ACK bus initiator: turns a one-cycle host request
// into exactly one bus cycle, with ACK timeout and a one-cycle recovery gap.
module wb_initiator #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 8
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReq,
   input  logic        iReqWE,
   input  logic [31:0] iReqADR,
   input  logic [31:0] iReqDAT,
   output logic        oBusy,
   output logic        oDone,
   output logic [31:0] oRdData,
   output logic        oTimeout,
   output logic [31:0] oADR,
   output logic [31:0] oDAT,
   input  logic [31:0] iDAT,
   output logic        oSTB,
   output logic        oWE,
   input  logic        iACK
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      RECOVER
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [31:0]      rdData_q, rdData_d;
   logic             timeout_q, timeout_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic             stb_q, stb_d;
   logic             we_q, we_d;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdData_q  <= '0;
         timeout_q <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rdData_q  <= rdData_d;
         timeout_q <= timeout_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
      end
   end

   // ACK is tested before the timeout so a late ACK on the last edge still wins.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rdData_d  = rdData_q;
      timeout_d = timeout_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      stb_d     = stb_q;
      we_d      = we_q;
      unique case (state_q)
         IDLE: begin
            if (iReq) begin
               adr_d     = iReqADR;
               dat_d     = iReqDAT;
               we_d      = iReqWE;
               stb_d     = 1'b1;
               busy_d    = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = '0;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (iACK) begin
               stb_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  rdData_d = iDAT;
               end
               state_d = RECOVER;
            end else if (cnt_q == CNT_LAST) begin
               stb_d     = 1'b0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               state_d   = RECOVER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RECOVER: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oRdData  = rdData_q;
   assign oTimeout = timeout_q;
   assign oADR     = adr_q;
   assign oDAT     = dat_q;
   assign oSTB     = stb_q;
   assign oWE      = we_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed scenarios plus randomized
// transactions checked against a transaction-level model of the initiator.
module tb_wb_initiator;

   localparam int TO = 16;

   logic        iCLK;
   logic        iRST;
   logic        iReq;
   logic        iReqWE;
   logic [31:0] iReqADR;
   logic [31:0] iReqDAT;
   logic        oBusy;
   logic        oDone;
   logic [31:0] oRdData;
   logic        oTimeout;
   logic [31:0] oADR;
   logic [31:0] oDAT;
   logic [31:0] iDAT;
   logic        oSTB;
   logic        oWE;
   logic        iACK;

   int          checks;
   int          passes;
   logic [31:0] modelRd;

   wb_initiator #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iReqWE(iReqWE),
      .iReqADR(iReqADR), .iReqDAT(iReqDAT), .oBusy(oBusy), .oDone(oDone),
      .oRdData(oRdData), .oTimeout(oTimeout), .oADR(oADR), .oDAT(oDAT),
      .iDAT(iDAT), .oSTB(oSTB), .oWE(oWE), .iACK(iACK)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   // One transaction; delay = STB-high edges before the ACK edge (>= TO means no ACK).
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                                input int delay, input logic [31:0] rdat);
      int  stbSeen;
      int  expStb;
      bit  expTo;
      bit  finished;
      expTo  = (delay >= TO);
      expStb = expTo ? TO : delay + 1;
      if (!expTo && !we) modelRd = rdat;
      @(negedge iCLK);
      iReq = 1'b1; iReqWE = we; iReqADR = adr; iReqDAT = wdat;
      iACK = 1'($urandom_range(0, 1)); iDAT = $urandom;
      @(posedge iCLK); #1;
      iReq = 1'b0; iReqADR = $urandom; iReqDAT = $urandom; iReqWE = 1'($urandom_range(0, 1));
      checkOutput("acceptBusy", 32'(oBusy), 32'd1);
      checkOutput("acceptStb", 32'(oSTB), 32'd1);
      checkOutput("acceptTimeoutClr", 32'(oTimeout), 32'd0);
      checkOutput("acceptAdr", oADR, adr);
      stbSeen  = 0;
      finished = 0;
      for (int cyc = 0; cyc < TO + 8 && !finished; cyc++) begin
         @(negedge iCLK);
         if (oDone) begin
            checkOutput("doneStbLow", 32'(oSTB), 32'd0);
            checkOutput("doneBusy", 32'(oBusy), 32'd1);
            checkOutput("doneTimeout", 32'(oTimeout), 32'(expTo));
            checkOutput("doneRdData", oRdData, modelRd);
            checkOutput("stbCycles", 32'(stbSeen), 32'(expStb));
            checkOutput("holdAdr", oADR, adr);
            checkOutput("holdDat", oDAT, wdat);
            checkOutput("holdWe", 32'(oWE), 32'(we));
            iACK = 1'($urandom_range(0, 1)); iDAT = $urandom;
            @(negedge iCLK);
            checkOutput("donePulseWidth", 32'(oDone), 32'd0);
            checkOutput("idleBusy", 32'(oBusy), 32'd0);
            finished = 1;
         end else if (oSTB) begin
            iACK = (stbSeen == delay);
            iDAT = iACK ? rdat : $urandom;
            stbSeen++;
         end else begin
            iACK = 1'($urandom_range(0, 1));
            iDAT = $urandom;
         end
      end
      if (!finished) checkOutput("doneWithinBound", 32'd0, 32'd1);
      iACK = 1'b0;
   endtask

   // iReq held high with immediate ACKs: one accept every three edges.
   task automatic runBackToBack();
      int   strobes;
      int   dones;
      int   lowRun;
      int   minGap;
      logic prevStb;
      strobes = 0; dones = 0; lowRun = 0; minGap = 1000; prevStb = 1'b0;
      @(negedge iCLK);
      iReq = 1'b1; iReqWE = 1'b0; iReqADR = 32'h0000_0100;
      iACK = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge iCLK);
         @(negedge iCLK);
         if (oDone) dones++;
         if (oSTB && !prevStb) begin
            if (strobes > 0 && lowRun < minGap) minGap = lowRun;
            strobes++;
         end
         lowRun  = oSTB ? 0 : lowRun + 1;
         prevStb = oSTB;
         iACK = oSTB;
         iDAT = 32'hB2B0_0000 + 32'(k);
         if (oSTB) modelRd = iDAT;
      end
      iReq = 1'b0; iACK = 1'b0;
      checkOutput("b2bStrobes", 32'(strobes), 32'd4);
      checkOutput("b2bDones", 32'(dones), 32'd4);
      checkOutput("b2bMinGap", 32'(minGap), 32'd2);
      checkOutput("b2bRdData", oRdData, modelRd);
      checkOutput("b2bIdle", 32'(oBusy), 32'd0);
   endtask

   initial begin
      checks = 0; passes = 0; modelRd = '0;
      iRST = 1'b0; iReq = 1'b0; iReqWE = 1'b0; iReqADR = '0; iReqDAT = '0;
      iDAT = '0; iACK = 1'b0;
      repeat (2) @(negedge iCLK);
      checkOutput("rstBusy", 32'(oBusy), 32'd0);
      checkOutput("rstDone", 32'(oDone), 32'd0);
      checkOutput("rstRdData", oRdData, 32'd0);
      checkOutput("rstTimeout", 32'(oTimeout), 32'd0);
      checkOutput("rstAdr", oADR, 32'd0);
      checkOutput("rstDat", oDAT, 32'd0);
      checkOutput("rstStb", 32'(oSTB), 32'd0);
      checkOutput("rstWe", 32'(oWE), 32'd0);
      iRST = 1'b1;

      $display("[TB] read with immediate ACK");
      applyStimulus(1'b0, 32'h0200_0800, 32'h0, 0, 32'h0000_00AB);
      $display("[TB] write with ACK after 3 cycles");
      applyStimulus(1'b1, 32'h0200_0804, 32'h0000_00CD, 3, 32'hDEAD_BEEF);
      $display("[TB] read with no ACK");
      applyStimulus(1'b0, 32'h0200_0808, 32'h0, 100, 32'h0);
      $display("[TB] ACK on the timeout edge");
      applyStimulus(1'b0, 32'h0200_080C, 32'h0, TO - 1, 32'h1234_5678);
      $display("[TB] back-to-back requests");
      runBackToBack();

      $display("[TB] reset during a strobe");
      @(negedge iCLK);
      iReq = 1'b1; iReqWE = 1'b0; iReqADR = 32'h0300_0000;
      @(posedge iCLK); #1;
      iReq = 1'b0;
      repeat (3) @(negedge iCLK);
      checkOutput("preResetStb", 32'(oSTB), 32'd1);
      #2 iRST = 1'b0;
      #1;
      checkOutput("asyncRstStb", 32'(oSTB), 32'd0);
      checkOutput("asyncRstBusy", 32'(oBusy), 32'd0);
      checkOutput("asyncRstDone", 32'(oDone), 32'd0);
      checkOutput("asyncRstRdData", oRdData, 32'd0);
      modelRd = '0;
      @(negedge iCLK);
      iRST = 1'b1;
      applyStimulus(1'b0, 32'h0300_0004, 32'h0, 1, 32'hC0DE_0001);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 25; n++) begin
         int d;
         d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 3, TO + 4))
                                         : int'($urandom_range(0, 5));
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, d, $urandom);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
